// File: rtl/ball_motion_if.sv
// -----------------------------------------------------------------------------
// ball_motion_if
// Purpose : bundles the velocity-write request and the ball motion status into
//           one interface.
//           - master modport: frame pulse and velocity write are driven, the
//             ball state is observed (producer / testbench side).
//           - slave modport : the ball_motion block consumes the writes and
//             drives the ball state.
// Signals :
//   startOfFrame        one-cycle pulse per video frame
//   velocityWriteEnable load inVelocityX/inVelocityY this cycle
//   inVelocityX/Y       new signed velocity, 1/64 pixel per frame
//   topLeftX/Y          integer top-left pixel of the ball
//   velocityX/Y         current signed velocity
//   moving              velocity non-zero
//   stoppedPulse        friction brought the ball to rest
//   borderHitPulse      a cushion reflection happened
// Optional : POSITION_LOAD_EN adds positionWriteEnable, inPositionX and
//            inPositionY for the cue-ball respawn.
// -----------------------------------------------------------------------------
interface ball_motion_if;
    logic               startOfFrame;
    logic               velocityWriteEnable;
    logic signed [10:0] inVelocityX;
    logic signed [10:0] inVelocityY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic signed [10:0] velocityX;
    logic signed [10:0] velocityY;
    logic               moving;
    logic               stoppedPulse;
    logic               borderHitPulse;
`ifdef POSITION_LOAD_EN
    logic               positionWriteEnable;
    logic signed [10:0] inPositionX;
    logic signed [10:0] inPositionY;

    modport master (
        output startOfFrame, velocityWriteEnable, inVelocityX, inVelocityY,
               positionWriteEnable, inPositionX, inPositionY,
        input  topLeftX, topLeftY, velocityX, velocityY, moving,
               stoppedPulse, borderHitPulse
    );
    modport slave (
        input  startOfFrame, velocityWriteEnable, inVelocityX, inVelocityY,
               positionWriteEnable, inPositionX, inPositionY,
        output topLeftX, topLeftY, velocityX, velocityY, moving,
               stoppedPulse, borderHitPulse
    );
`else
    modport master (
        output startOfFrame, velocityWriteEnable, inVelocityX, inVelocityY,
        input  topLeftX, topLeftY, velocityX, velocityY, moving,
               stoppedPulse, borderHitPulse
    );
    modport slave (
        input  startOfFrame, velocityWriteEnable, inVelocityX, inVelocityY,
        output topLeftX, topLeftY, velocityX, velocityY, moving,
               stoppedPulse, borderHitPulse
    );
`endif
endinterface

// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
// Purpose : owns the ball's motion state. Once per video frame it integrates
//           velocity into a fixed-point position, reflects off the table
//           cushions and applies friction decay. Velocity writes may arrive in
//           any cycle and abort the frame in progress.
// Ports   :
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    ball_motion_if.slave (frame pulse, velocity write, ball state)
// Frame sequence : WAIT -> INTEGRATE -> BORDER -> FRICTION -> WAIT, one cycle
//                  each; the final position is visible 3 cycles after
//                  startOfFrame.
// Optional : define POSITION_LOAD_EN to enable the cue-ball respawn port
//            (position load clears velocity and the frame counter).
// -----------------------------------------------------------------------------
module ball_motion #(
    parameter int FIXED_SHIFT     = 6,
    parameter int INIT_X          = 320,
    parameter int INIT_Y          = 240,
    parameter int X_MIN           = 32,
    parameter int X_MAX           = 576,
    parameter int Y_MIN           = 32,
    parameter int Y_MAX           = 416,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 2
) (
    input  logic         clk,
    input  logic         reset,
    ball_motion_if.slave bus
);

    localparam int PW = 11 + FIXED_SHIFT;
    localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

    localparam logic signed [10:0]   C_X_MIN    = 11'(X_MIN);
    localparam logic signed [10:0]   C_X_MAX    = 11'(X_MAX);
    localparam logic signed [10:0]   C_Y_MIN    = 11'(Y_MIN);
    localparam logic signed [10:0]   C_Y_MAX    = 11'(Y_MAX);
    localparam logic signed [10:0]   C_STEP     = 11'(FRICTION_STEP);
    localparam logic [CW-1:0]        C_CNT_LAST = CW'(FRICTION_PERIOD - 1);
    localparam logic signed [PW-1:0] C_POS_X_INIT = PW'(INIT_X) <<< FIXED_SHIFT;
    localparam logic signed [PW-1:0] C_POS_Y_INIT = PW'(INIT_Y) <<< FIXED_SHIFT;
    localparam logic signed [PW-1:0] C_POS_X_MIN  = PW'(X_MIN) <<< FIXED_SHIFT;
    localparam logic signed [PW-1:0] C_POS_X_MAX  = PW'(X_MAX) <<< FIXED_SHIFT;
    localparam logic signed [PW-1:0] C_POS_Y_MIN  = PW'(Y_MIN) <<< FIXED_SHIFT;
    localparam logic signed [PW-1:0] C_POS_Y_MAX  = PW'(Y_MAX) <<< FIXED_SHIFT;

    typedef enum logic [1:0] {
        S_WAIT      = 2'd0,
        S_INTEGRATE = 2'd1,
        S_BORDER    = 2'd2,
        S_FRICTION  = 2'd3
    } state_t;

    // Sign-extend a velocity to position width so it adds in fractional units.
    function automatic logic signed [PW-1:0] ext_vel(input logic signed [10:0] v);
        ext_vel = {{FIXED_SHIFT{v[10]}}, v};
    endfunction

    // |v|, with -1024 saturating to +1023 because +1024 is not representable.
    function automatic logic signed [10:0] abs_sat(input logic signed [10:0] v);
        if (v == 11'sh400) begin
            abs_sat = 11'sh3FF;
        end else if (v[10]) begin
            abs_sat = -v;
        end else begin
            abs_sat = v;
        end
    endfunction

    // -|v|; a negative input is already the answer, so -1024 needs no clamp.
    function automatic logic signed [10:0] neg_abs(input logic signed [10:0] v);
        if (v[10]) begin
            neg_abs = v;
        end else begin
            neg_abs = -v;
        end
    endfunction

    // Move v toward zero by C_STEP without crossing the sign.
    function automatic logic signed [10:0] friction(input logic signed [10:0] v);
        if (v[10]) begin
            if (v < -C_STEP) begin
                friction = v + C_STEP;
            end else begin
                friction = 11'sd0;
            end
        end else if (v > C_STEP) begin
            friction = v - C_STEP;
        end else begin
            friction = 11'sd0;
        end
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [PW-1:0] r_pos_x, r_pos_y;
    logic signed [PW-1:0] w_pos_x_nxt, w_pos_y_nxt;
    logic signed [10:0]   r_vel_x, r_vel_y;
    logic signed [10:0]   w_vel_x_nxt, w_vel_y_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_border_hit, w_border_hit_nxt;
    logic                 r_stopped, w_stopped_nxt;

    logic signed [10:0]   w_int_x, w_int_y;
    logic                 w_low_x, w_high_x, w_low_y, w_high_y;
    logic signed [10:0]   w_fric_x, w_fric_y;
    logic                 w_pos_load;
    logic signed [PW-1:0] w_load_x, w_load_y;

`ifdef POSITION_LOAD_EN
    assign w_pos_load = bus.positionWriteEnable;
    assign w_load_x   = {bus.inPositionX, {FIXED_SHIFT{1'b0}}};
    assign w_load_y   = {bus.inPositionY, {FIXED_SHIFT{1'b0}}};
`else
    assign w_pos_load = 1'b0;
    assign w_load_x   = C_POS_X_INIT;
    assign w_load_y   = C_POS_Y_INIT;
`endif

    // Integer pixel part of the position (arithmetic shift by FIXED_SHIFT).
    assign w_int_x  = r_pos_x[PW-1:FIXED_SHIFT];
    assign w_int_y  = r_pos_y[PW-1:FIXED_SHIFT];
    assign w_low_x  = (w_int_x < C_X_MIN);
    assign w_high_x = (w_int_x > C_X_MAX);
    assign w_low_y  = (w_int_y < C_Y_MIN);
    assign w_high_y = (w_int_y > C_Y_MAX);
    assign w_fric_x = friction(r_vel_x);
    assign w_fric_y = friction(r_vel_y);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; any write aborts the frame back to WAIT.
    always_comb begin
        w_state_nxt = r_state;
        if (w_pos_load || bus.velocityWriteEnable) begin
            w_state_nxt = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (bus.startOfFrame) begin
                        w_state_nxt = S_INTEGRATE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_INTEGRATE: w_state_nxt = S_BORDER;
                S_BORDER:    w_state_nxt = S_FRICTION;
                S_FRICTION:  w_state_nxt = S_WAIT;
                default:     w_state_nxt = S_WAIT;
            endcase
        end
    end

    // Per-state datapath updates and pulse requests for the next cycle.
    always_comb begin
        w_pos_x_nxt      = r_pos_x;
        w_pos_y_nxt      = r_pos_y;
        w_vel_x_nxt      = r_vel_x;
        w_vel_y_nxt      = r_vel_y;
        w_cnt_nxt        = r_cnt;
        w_border_hit_nxt = 1'b0;
        w_stopped_nxt    = 1'b0;
        if (w_pos_load) begin
            w_pos_x_nxt = w_load_x;
            w_pos_y_nxt = w_load_y;
            w_vel_x_nxt = 11'sd0;
            w_vel_y_nxt = 11'sd0;
            w_cnt_nxt   = {CW{1'b0}};
        end else if (bus.velocityWriteEnable) begin
            // The write replaces whatever this cycle's step would have done.
            w_vel_x_nxt = bus.inVelocityX;
            w_vel_y_nxt = bus.inVelocityY;
            w_cnt_nxt   = {CW{1'b0}};
        end else begin
            case (r_state)
                S_INTEGRATE: begin
                    w_pos_x_nxt = r_pos_x + ext_vel(r_vel_x);
                    w_pos_y_nxt = r_pos_y + ext_vel(r_vel_y);
                end
                S_BORDER: begin
                    if (w_low_x) begin
                        w_pos_x_nxt = C_POS_X_MIN;
                        w_vel_x_nxt = abs_sat(r_vel_x);
                    end else if (w_high_x) begin
                        w_pos_x_nxt = C_POS_X_MAX;
                        w_vel_x_nxt = neg_abs(r_vel_x);
                    end else begin
                        w_pos_x_nxt = r_pos_x;
                        w_vel_x_nxt = r_vel_x;
                    end
                    if (w_low_y) begin
                        w_pos_y_nxt = C_POS_Y_MIN;
                        w_vel_y_nxt = abs_sat(r_vel_y);
                    end else if (w_high_y) begin
                        w_pos_y_nxt = C_POS_Y_MAX;
                        w_vel_y_nxt = neg_abs(r_vel_y);
                    end else begin
                        w_pos_y_nxt = r_pos_y;
                        w_vel_y_nxt = r_vel_y;
                    end
                    w_border_hit_nxt = w_low_x | w_high_x | w_low_y | w_high_y;
                end
                S_FRICTION: begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_cnt_nxt     = {CW{1'b0}};
                        w_vel_x_nxt   = w_fric_x;
                        w_vel_y_nxt   = w_fric_y;
                        w_stopped_nxt = ((r_vel_x != 11'sd0) || (r_vel_y != 11'sd0)) &&
                                        (w_fric_x == 11'sd0) && (w_fric_y == 11'sd0);
                    end else begin
                        w_cnt_nxt     = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_cnt_nxt = r_cnt;
                end
            endcase
        end
    end

    // Motion state and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos_x      <= C_POS_X_INIT;
            r_pos_y      <= C_POS_Y_INIT;
            r_vel_x      <= 11'sd0;
            r_vel_y      <= 11'sd0;
            r_cnt        <= {CW{1'b0}};
            r_border_hit <= 1'b0;
            r_stopped    <= 1'b0;
        end else begin
            r_pos_x      <= w_pos_x_nxt;
            r_pos_y      <= w_pos_y_nxt;
            r_vel_x      <= w_vel_x_nxt;
            r_vel_y      <= w_vel_y_nxt;
            r_cnt        <= w_cnt_nxt;
            r_border_hit <= w_border_hit_nxt;
            r_stopped    <= w_stopped_nxt;
        end
    end

    assign bus.topLeftX       = w_int_x;
    assign bus.topLeftY       = w_int_y;
    assign bus.velocityX      = r_vel_x;
    assign bus.velocityY      = r_vel_y;
    assign bus.moving         = (r_vel_x != 11'sd0) || (r_vel_y != 11'sd0);
    assign bus.stoppedPulse   = r_stopped;
    assign bus.borderHitPulse = r_border_hit;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus pushes the expected end-of-frame
// state (from a plain-arithmetic model of the frame rules) into a queue; a
// monitor pops and compares whenever the DUT starts a frame.
module tb_ball_motion;
    localparam int INIT_X = 320, INIT_Y = 240;
    localparam int X_MIN = 32, X_MAX = 576, Y_MIN = 32, Y_MAX = 416;
    localparam int PERIOD = 4, STEP = 2, ONE = 64;

    typedef struct {
        int tlx; int tly; int vx; int vy; int hit; int stop;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_motion_if bus();
    ball_motion dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t exp_q[$];
    int n_tests = 0, n_fail = 0;
    int spurious = 0, windows_seen = 0, frames_issued = 0;
    bit in_window = 1'b0;
    int m_px, m_py, m_vx, m_vy, m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_px = INIT_X * ONE; m_py = INIT_Y * ONE;
        m_vx = 0; m_vy = 0; m_cnt = 0;
    endfunction

    function automatic void model_write(input int vx, input int vy);
        m_vx = vx; m_vy = vy; m_cnt = 0;
    endfunction

    function automatic int toward_zero(input int v);
        if (v > 0) return (v > STEP) ? v - STEP : 0;
        if (v < 0) return (v < -STEP) ? v + STEP : 0;
        return 0;
    endfunction

    // Mathematical |v|, limited to the largest storable velocity.
    function automatic int mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 1023) ? 1023 : a;
    endfunction

    function automatic exp_t snap(input int hit, input int stop);
        exp_t e;
        e.tlx = m_px >>> 6; e.tly = m_py >>> 6;
        e.vx = m_vx; e.vy = m_vy; e.hit = hit; e.stop = stop;
        return e;
    endfunction

    // One whole frame: move, bounce, then friction every PERIOD frames.
    function automatic exp_t model_frame();
        int hit, stop;
        bit was_moving;
        hit = 0; stop = 0;
        m_px += m_vx; m_py += m_vy;
        if ((m_px >>> 6) < X_MIN) begin m_px = X_MIN * ONE; m_vx = mag(m_vx); hit = 1; end
        else if ((m_px >>> 6) > X_MAX) begin m_px = X_MAX * ONE; m_vx = (m_vx < 0) ? m_vx : -m_vx; hit = 1; end
        if ((m_py >>> 6) < Y_MIN) begin m_py = Y_MIN * ONE; m_vy = mag(m_vy); hit = 1; end
        else if ((m_py >>> 6) > Y_MAX) begin m_py = Y_MAX * ONE; m_vy = (m_vy < 0) ? m_vy : -m_vy; hit = 1; end
        if (m_cnt == PERIOD - 1) begin
            m_cnt = 0;
            was_moving = (m_vx != 0) || (m_vy != 0);
            m_vx = toward_zero(m_vx); m_vy = toward_zero(m_vy);
            stop = (was_moving && m_vx == 0 && m_vy == 0) ? 1 : 0;
        end else begin
            m_cnt++;
        end
        return snap(hit, stop);
    endfunction

    // Monitor: each accepted frame start opens a 4-cycle window; pulses are
    // counted in it and the final state compared with the queued expectation.
    initial begin
        exp_t e;
        int hits, stops;
        forever begin
            @(posedge clk);
            if (bus.startOfFrame === 1'b1 && reset === 1'b0) begin
                in_window = 1'b1;
                windows_seen++;
                hits = 0; stops = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    hits += int'(bus.borderHitPulse);
                    stops += int'(bus.stoppedPulse);
                end
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL scoreboard: frame with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    check("topLeftX", int'(bus.topLeftX), e.tlx);
                    check("topLeftY", int'(bus.topLeftY), e.tly);
                    check("velocityX", int'(bus.velocityX), e.vx);
                    check("velocityY", int'(bus.velocityY), e.vy);
                    check("moving", int'(bus.moving), (e.vx != 0 || e.vy != 0) ? 1 : 0);
                    check("borderHitPulse_count", hits, e.hit);
                    check("stoppedPulse_count", stops, e.stop);
                end
                @(posedge clk);
                in_window = 1'b0;
            end
        end
    end

    // Pulses must never appear outside a frame window.
    always @(negedge clk) begin
        if (!in_window && reset === 1'b0 && (bus.borderHitPulse === 1'b1 || bus.stoppedPulse === 1'b1))
            spurious++;
    end

    task automatic write_vel(input int vx, input int vy);
        @(negedge clk);
        bus.velocityWriteEnable = 1'b1;
        bus.inVelocityX = 11'(vx); bus.inVelocityY = 11'(vy);
        model_write(vx, vy);
        @(negedge clk);
        bus.velocityWriteEnable = 1'b0;
    endtask

    // extra_sof re-pulses startOfFrame while the frame is in progress.
    task automatic do_frame(input bit extra_sof);
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        exp_q.push_back(model_frame());
        frames_issued++;
        @(negedge clk);
        bus.startOfFrame = extra_sof;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int vx, vy, guard;
        bus.startOfFrame = 1'b0;
        bus.velocityWriteEnable = 1'b0;
        bus.inVelocityX = 11'sd0; bus.inVelocityY = 11'sd0;
`ifdef POSITION_LOAD_EN
        bus.positionWriteEnable = 1'b0;
        bus.inPositionX = 11'sd0; bus.inPositionY = 11'sd0;
`endif
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_topLeftX", int'(bus.topLeftX), 320);
        check("reset_topLeftY", int'(bus.topLeftY), 240);
        check("reset_moving", int'(bus.moving), 0);
        check("reset_pulses", int'(bus.borderHitPulse) + int'(bus.stoppedPulse), 0);
        reset = 1'b0;

        // Idle frames leave the ball where it is.
        repeat (5) do_frame(1'b0);

        // Plain integration.
        write_vel(64, -128);
        do_frame(1'b0);
        check("t2_topLeftX", int'(bus.topLeftX), 321);
        check("t2_topLeftY", int'(bus.topLeftY), 238);
        check("t2_moving", int'(bus.moving), 1);

        // Drive to the right cushion, step back to 575, then bounce at 576.
        write_vel(1023, 0);
        guard = 0;
        while (m_px != X_MAX * ONE && guard < 60) begin
            do_frame(1'b0);
            guard++;
        end
        check("t3_reached_wall", int'(bus.topLeftX), 576);
        write_vel(-64, 0);
        do_frame(1'b0);
        check("t3_at_575", int'(bus.topLeftX), 575);
        write_vel(128, 0);
        do_frame(1'b0);
        check("t3_clamped_x", int'(bus.topLeftX), 576);
        check("t3_reflected_vx", int'(bus.velocityX), -128);

        // Friction: 3 -> 1 after frame 4, 1 -> 0 after frame 8.
        write_vel(3, 0);
        repeat (4) do_frame(1'b0);
        check("t4_vx_after4", int'(bus.velocityX), 1);
        repeat (4) do_frame(1'b0);
        check("t4_vx_after8", int'(bus.velocityX), 0);
        check("t4_moving", int'(bus.moving), 0);

        // Velocity write landing while the FSM is in BORDER.
        write_vel(-100, 40);
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        m_px += m_vx; m_py += m_vy;
        model_write(50, 50);
        exp_q.push_back(snap(0, 0));
        frames_issued++;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        @(negedge clk);
        bus.velocityWriteEnable = 1'b1;
        bus.inVelocityX = 11'sd50; bus.inVelocityY = 11'sd50;
        @(negedge clk);
        bus.velocityWriteEnable = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_vx", int'(bus.velocityX), 50);
        check("t5_vy", int'(bus.velocityY), 50);
        do_frame(1'b0);

        // Reset while INTEGRATE is active.
        write_vel(200, 0);
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        model_reset();
        exp_q.push_back(snap(0, 0));
        frames_issued++;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_reset_x", int'(bus.topLeftX), 320);
        check("t6_reset_vx", int'(bus.velocityX), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        do_frame(1'b0);
        check("t6_after_x", int'(bus.topLeftX), 320);
        check("t6_after_y", int'(bus.topLeftY), 240);

        // Randomized velocities, frames and ignored mid-frame frame pulses.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    vx = int'($urandom_range(0, 2047)) - 1024;
                    vy = int'($urandom_range(0, 2047)) - 1024;
                end else begin
                    vx = int'($urandom_range(0, 16)) - 8;
                    vy = int'($urandom_range(0, 16)) - 8;
                end
                write_vel(vx, vy);
            end
            do_frame($urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        check("idle_pulses", spurious, 0);
        check("frames_seen", windows_seen, frames_issued);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Consumer end of the velocity write interface: accepts velocity writes (`inVelocityX`/`inVelocityY` qualified by `velocityWriteEnable`) and owns the ball's motion state.
- Once per video frame, integrates velocity into a fixed-point position, reflects off the table cushions and applies friction decay.
- Drives the ball's top-left pixel coordinate to the drawing and hit-detection logic.

Parameters:
- `FIXED_SHIFT`, 6, fractional bits of position; velocity unit is 1/64 pixel per frame.
- `INIT_X`, 320, reset top-left X in pixels.
- `INIT_Y`, 240, reset top-left Y in pixels.
- `X_MIN`, 32, leftmost legal top-left X.
- `X_MAX`, 576, rightmost legal top-left X.
- `Y_MIN`, 32, topmost legal top-left Y.
- `Y_MAX`, 416, bottommost legal top-left Y.
- `FRICTION_PERIOD`, 4, frames between friction steps (≥1).
- `FRICTION_STEP`, 2, velocity magnitude removed per friction step.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `startOfFrame`  in  1  one-cycle pulse per video frame
- `velocityWriteEnable`  in  1  load velocity this cycle
- `inVelocityX`  in  11 signed  new X velocity
- `inVelocityY`  in  11 signed  new Y velocity
- `topLeftX`  out  11 signed  integer ball X, i.e. `posX >>> FIXED_SHIFT`
- `topLeftY`  out  11 signed  integer ball Y
- `velocityX`  out  11 signed  current X velocity
- `velocityY`  out  11 signed  current Y velocity
- `moving`  out  1  velocity non-zero
- `stoppedPulse`  out  1  one cycle when friction brings velocity to zero
- `borderHitPulse`  out  1  one cycle on any cushion reflection

Behaviour:
- Reset (async, active-high):
  - `posX = INIT_X<<FIXED_SHIFT`, `posY = INIT_Y<<FIXED_SHIFT`.
  - velocity 0, frame counter 0, state `WAIT`.
  - All pulses 0; `moving` 0.
- Position registers are signed, 11+`FIXED_SHIFT` bits. Velocity is sign-extended before add.
- FSM states: `WAIT`, `INTEGRATE`, `BORDER`, `FRICTION`.
  - `WAIT`: on `startOfFrame` → `INTEGRATE`.
  - `INTEGRATE` (1 cycle): `posX += vX`, `posY += vY` → `BORDER`.
  - `BORDER` (1 cycle), per axis, evaluated independently:
    - integer part < MIN: pos = MIN<<S; v = |v|.
    - integer part > MAX: pos = MAX<<S; v = −|v|.
    - Negation of −1024 saturates to +1023.
    - `borderHitPulse` = 1 next cycle if either axis clamped.
    - → `FRICTION`.
  - `FRICTION` (1 cycle):
    - If frameCnt == `FRICTION_PERIOD`−1: frameCnt = 0; each non-zero component moves toward 0 by `FRICTION_STEP`, clamped at 0 (never crosses sign).
    - Otherwise frameCnt++.
    - `stoppedPulse` = 1 next cycle if velocity was non-zero before this step and is zero after.
    - → `WAIT`.
- Latency: `topLeftX`/`topLeftY` reflect the frame's final position 3 cycles after `startOfFrame`.
- `moving` is combinational from the velocity registers.
- `startOfFrame` outside `WAIT` is ignored; no queueing.
- Velocity write accepted in any state:
  - Loads `vX`/`vY` and clears frameCnt.
  - If in `INTEGRATE`/`BORDER`/`FRICTION`: the write wins over any velocity update that cycle; FSM returns to `WAIT`; position updates already committed stay.
  - A write of 0,0 does not raise `stoppedPulse`.
- Zero velocity still runs the FSM each frame; position unchanged, no pulses.

Optional Feature:
- Macro: `POSITION_LOAD_EN` (cue-ball respawn).
- With the macro defined:
  - Adds ports `positionWriteEnable` (in, 1), `inPositionX` (in, 11 signed), `inPositionY` (in, 11 signed).
  - On `positionWriteEnable`: `pos = in<<FIXED_SHIFT` (fraction cleared), velocity 0, frameCnt 0, FSM → `WAIT`.
  - Overrides a simultaneous velocity write.
  - No pulse is raised.
- Without the macro: ports absent; position is changed only by reset and integration.

Test Plan:
1. Reset release → `topLeftX`=320, `topLeftY`=240, `moving`=0; 5 frames keep it unchanged with no pulses.
2. Write vX=+64, vY=−128; 1 frame → 3 cycles later `topLeftX`=321, `topLeftY`=238, `moving`=1.
3. Ball at X=575, vX=+128; 1 frame → `topLeftX`=576, `velocityX`=−128, `borderHitPulse` high 1 cycle.
4. vX=+3, vY=0, period 4, step 2 → after frame 4 vX=1, after frame 8 vX=0 with `stoppedPulse` for 1 cycle, `moving`=0.
5. Velocity write (+50,+50) during `BORDER` → FSM in `WAIT` next cycle, velocity (+50,+50), frameCnt 0, no pulses.
6. Assert `reset` mid-`INTEGRATE` with vX=+200 → immediate return to (320,240), velocity 0; a `startOfFrame` after release leaves position unchanged.
